// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Request FIFO -> ALU operand register -> result register, with
//            valid/ready handshakes on both the request and the result side.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int DWIDTH  = 32,
    parameter int OPWIDTH = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPWIDTH-1:0]         in_op,
    input  logic [DWIDTH-1:0]          in_a,
    input  logic [DWIDTH-1:0]          in_b,
    output logic [OPWIDTH-1:0]         alu_op,
    output logic [DWIDTH-1:0]          alu_a,
    output logic [DWIDTH-1:0]          alu_b,
    input  logic [DWIDTH-1:0]          alu_res,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OPWIDTH-1:0]         res_op,
    output logic [DWIDTH-1:0]          res_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [OPWIDTH-1:0] r_mem_op [DEPTH];
    logic [DWIDTH-1:0]  r_mem_a  [DEPTH];
    logic [DWIDTH-1:0]  r_mem_b  [DEPTH];

    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_e_valid;
    logic [OPWIDTH-1:0] r_alu_op;
    logic [DWIDTH-1:0]  r_alu_a;
    logic [DWIDTH-1:0]  r_alu_b;
    logic               r_res_valid;
    logic [OPWIDTH-1:0] r_res_op;
    logic [DWIDTH-1:0]  r_res_data;

    logic w_push;
    logic w_r_free;
    logic w_e_adv;
    logic w_e_load;

    // in_ready depends only on occupancy, never on res_ready.
    assign in_ready = (r_count != C_FULL);
    assign w_push   = in_valid && in_ready;
    assign w_r_free = !r_res_valid || res_ready;
    assign w_e_adv  = r_e_valid && w_r_free;
    assign w_e_load = (r_count != '0) && (!r_e_valid || w_e_adv);

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wptr] <= in_op;
            r_mem_a[r_wptr]  <= in_a;
            r_mem_b[r_wptr]  <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_e_valid   <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_op    <= '0;
            r_res_data  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_e_load) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_e_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // E keeps its operands when idle so the ALU inputs never glitch.
            if (w_e_load) begin
                r_e_valid <= 1'b1;
                r_alu_op  <= r_mem_op[r_rptr];
                r_alu_a   <= r_mem_a[r_rptr];
                r_alu_b   <= r_mem_b[r_rptr];
            end else if (w_e_adv) begin
                r_e_valid <= 1'b0;
            end

            if (w_e_adv) begin
                r_res_valid <= 1'b1;
                r_res_op    <= r_alu_op;
                r_res_data  <= alu_res;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_op    = r_res_op;
    assign res_data  = r_res_data;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Self-checking bench for alu_issue_stage with an adder as the ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    localparam int DW    = 32;
    localparam int OW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_op;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_op;
    logic [DW-1:0] res_data;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Expected results (op, a+b) in push order, and observed transfers.
    logic [OW+DW-1:0] exp_q[$];
    logic [OW+DW-1:0] got_q[$];
    int               got_t[$];

    assign alu_res = alu_a + alu_b;

    alu_issue_stage #(.DWIDTH(DW), .OPWIDTH(OW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_op(res_op), .res_data(res_data), .count(count)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: logs the handshakes the next rising edge will
    // perform, then advances to the following falling edge.
    task automatic cycle();
        logic [DW-1:0] s;
        s = in_a + in_b;
        if (in_valid && in_ready) exp_q.push_back({in_op, s});
        if (res_valid && res_ready) begin
            got_q.push_back({res_op, res_data});
            got_t.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic rand_req();
        in_op = OW'($urandom);
        in_a  = $urandom;
        in_b  = $urandom;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, res_valid, count, alu_op, alu_a, alu_b, res_op, res_data} !== {1'b1, 1'b0, {CW{1'b0}}, {OW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, {OW{1'b0}}, {DW{1'b0}}}) begin
            $display("FAIL reset_state: ready=%0b rv=%0b cnt=%0d aop=%0h a=%0h b=%0h rop=%0h rd=%0h, want ready=1 and all else 0",
                     in_ready, res_valid, count, alu_op, alu_a, alu_b, res_op, res_data);
        end else n_pass++;
    endtask

    task automatic test_single();
        clear_q();
        res_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'd1; in_a = 32'd5; in_b = 32'd7;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (count !== CW'(1) || res_valid !== 1'b0) begin
            $display("FAIL single_edge0: count=%0d rv=%0b, want 1/0", count, res_valid);
        end else n_pass++;
        cycle();
        n_checks++;
        if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'd1 || res_valid !== 1'b0) begin
            $display("FAIL single_edge1: a=%0d b=%0d op=%0d rv=%0b, want 5/7/1/0", alu_a, alu_b, alu_op, res_valid);
        end else n_pass++;
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd12 || res_op !== 4'd1) begin
            $display("FAIL single_edge2: rv=%0b data=%0d op=%0d, want 1/12/1", res_valid, res_data, res_op);
        end else n_pass++;
        cycle();
        n_checks++;
        if (res_valid !== 1'b0) begin
            $display("FAIL single_edge3: rv=%0b, want 0", res_valid);
        end else n_pass++;
    endtask

    task automatic test_streaming();
        int c0;
        int maxc;
        clear_q();
        maxc = 0;
        res_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_op = OW'(i); in_a = DW'(i); in_b = DW'(10 * i);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %0b, want 1", i, in_ready);
            else n_pass++;
            cycle();
            if (int'(count) > maxc) maxc = int'(count);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 8; k++) begin
            cycle();
            if (int'(count) > maxc) maxc = int'(count);
        end
        n_checks++;
        if (maxc > 1) $display("FAIL stream_count_max: got %0d, want <=1", maxc);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 8) $display("FAIL stream_results: got %0d results, want 8", got_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_q[i][DW-1:0] !== DW'(11 * i) || got_q[i][OW+DW-1:DW] !== OW'(i) || got_t[i] != c0 + 3 + i)
                    $display("FAIL stream_res[%0d]: data=%0d op=%0d at cycle %0d, want %0d/%0d at %0d",
                             i, got_q[i][DW-1:0], got_q[i][OW+DW-1:DW], got_t[i], 11 * i, i, c0 + 3 + i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] ra [7];
        logic [DW-1:0] rb [7];
        logic [DW-1:0] s0;
        clear_q();
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; rand_req(); ra[k] = in_a; rb[k] = in_b;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL full_accept[%0d]: ready=%0b, want 1", k, in_ready);
            else n_pass++;
            cycle();
        end
        rand_req(); ra[6] = in_a; rb[6] = in_b;
        s0 = ra[0] + rb[0];
        n_checks++;
        if (count !== CW'(DEPTH) || in_ready !== 1'b0 || res_valid !== 1'b1 || alu_a !== ra[1] || res_data !== s0)
            $display("FAIL full_state: cnt=%0d ready=%0b rv=%0b alu_a=%0h rd=%0h, want %0d/0/1/%0h/%0h",
                     count, in_ready, res_valid, alu_a, res_data, DEPTH, ra[1], s0);
        else n_pass++;
        repeat (3) cycle();
        n_checks++;
        if (in_ready !== 1'b0 || exp_q.size() != 6 || res_data !== s0 || alu_a !== ra[1])
            $display("FAIL full_hold: ready=%0b pushed=%0d rd=%0h alu_a=%0h, want 0/6/%0h/%0h",
                     in_ready, exp_q.size(), res_data, alu_a, s0, ra[1]);
        else n_pass++;
        res_ready = 1'b1;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || count !== CW'(DEPTH - 1))
            $display("FAIL full_release: ready=%0b cnt=%0d, want 1/%0d", in_ready, count, DEPTH - 1);
        else n_pass++;
        for (int k = 0; k < 30 && got_q.size() < 7; k++) begin
            if (exp_q.size() == 7) in_valid = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        n_checks++;
        if (got_q.size() != 7 || exp_q.size() != 7)
            $display("FAIL full_results: got %0d results of %0d pushed, want 7/7", got_q.size(), exp_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i] || got_q[i][DW-1:0] !== ra[i] + rb[i])
                    $display("FAIL full_res[%0d]: got %0h, want %0h", i, got_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        int sent;
        clear_q();
        sent = 0;
        in_valid = 1'b1; rand_req();
        for (int k = 0; k < 200 && got_q.size() < 12; k++) begin
            res_ready = (k % 2 == 0);
            in_valid  = (sent < 12);
            if (in_valid && in_ready) begin
                cycle();
                sent++;
                rand_req();
            end else cycle();
        end
        in_valid = 1'b0; res_ready = 1'b1;
        repeat (4) cycle();
        n_checks++;
        if (got_q.size() != 12 || exp_q.size() != 12)
            $display("FAIL wrap_count: got %0d results of %0d pushed, want 12/12", got_q.size(), exp_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) $display("FAIL wrap_res[%0d]: got %0h, want %0h", i, got_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_simul_push_pop();
        clear_q();
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; rand_req();
            cycle();
        end
        in_valid = 1'b0;
        n_checks++;
        if (count !== CW'(2)) $display("FAIL simul_pre: cnt=%0d, want 2", count);
        else n_pass++;
        in_valid = 1'b1; rand_req(); res_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (count !== CW'(2) || exp_q.size() != 5) $display("FAIL simul_post: cnt=%0d pushed=%0d, want 2/5", count, exp_q.size());
        else n_pass++;
        for (int k = 0; k < 20 && got_q.size() < 5; k++) cycle();
        n_checks++;
        if (got_q.size() != 5) $display("FAIL simul_results: got %0d results, want 5", got_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) $display("FAIL simul_res[%0d]: got %0h, want %0h", i, got_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int bad;
        clear_q();
        bad = 0;
        in_valid = 1'b0; rand_req();
        for (int k = 0; k < 400; k++) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rand_req();
            end
            res_ready = ($urandom_range(0, 9) < 6);
            if (in_ready !== (count != CW'(DEPTH)) || int'(count) > DEPTH) bad++;
            if (in_valid && in_ready) begin
                cycle();
                in_valid = 1'b0;
            end else cycle();
        end
        in_valid = 1'b0; res_ready = 1'b1;
        for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) cycle();
        n_checks++;
        if (bad != 0) $display("FAIL rand_ready_vs_count: %0d bad cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0)
            $display("FAIL rand_results: got %0d results, want %0d", got_q.size(), exp_q.size());
        else begin
            n_pass++;
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL rand_order: %0d mismatched results, want 0", bad);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; rand_req();
            cycle();
        end
        in_valid = 1'b0;
        n_checks++;
        if (count !== CW'(3) || res_valid !== 1'b1) $display("FAIL rstmid_pre: cnt=%0d rv=%0b, want 3/1", count, res_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, res_valid, count, alu_op, alu_a, alu_b, res_op, res_data} !== {1'b1, 1'b0, {CW{1'b0}}, {OW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, {OW{1'b0}}, {DW{1'b0}}})
            $display("FAIL rstmid_async: ready=%0b rv=%0b cnt=%0d a=%0h rd=%0h, want ready=1 and all else 0",
                     in_ready, res_valid, count, alu_a, res_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        res_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'd2; in_a = 32'd3; in_b = 32'd4;
        cycle();
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL rstmid_early: rv=%0b one edge after accept, want 0", res_valid);
        else n_pass++;
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd7 || res_op !== 4'd2)
            $display("FAIL rstmid_result: rv=%0b data=%0d op=%0d, want 1/7/2", res_valid, res_data, res_op);
        else n_pass++;
        repeat (5) cycle();
        n_checks++;
        if (got_q.size() != 1 || got_q[0][DW-1:0] !== 32'd7)
            $display("FAIL rstmid_stale: %0d results seen, want exactly 1 with data 7", got_q.size());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single();
        test_streaming();
        test_full();
        test_wrap();
        test_simul_push_pop();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
